// File: rtl/freelist_ctrl_if.sv
// Purpose : handshake bundle between the rename/commit/redirect logic and
//           freelist_ctrl.
// Signals : alloc_req0/1, alloc_ready, alloc_preg0/1   - rename allocation
//           free_vld0/1, free_preg0/1, free_ready      - commit frees
//           redirect, walk_vld0/1, walk_preg0/1,
//           walk_done                                  - redirect walk
// Modports: master = pipeline side, slave = freelist_ctrl
interface freelist_ctrl_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  alloc_req0;
    logic                  alloc_req1;
    logic                  alloc_ready;
    logic [DATA_WIDTH-1:0] alloc_preg0;
    logic [DATA_WIDTH-1:0] alloc_preg1;
    logic                  free_vld0;
    logic                  free_vld1;
    logic [DATA_WIDTH-1:0] free_preg0;
    logic [DATA_WIDTH-1:0] free_preg1;
    logic                  free_ready;
    logic                  redirect;
    logic                  walk_vld0;
    logic                  walk_vld1;
    logic [DATA_WIDTH-1:0] walk_preg0;
    logic [DATA_WIDTH-1:0] walk_preg1;
    logic                  walk_done;

    modport master (
        output alloc_req0, alloc_req1,
        input  alloc_ready, alloc_preg0, alloc_preg1,
        output free_vld0, free_vld1, free_preg0, free_preg1,
        input  free_ready,
        output redirect, walk_vld0, walk_vld1, walk_preg0, walk_preg1, walk_done
    );

    modport slave (
        input  alloc_req0, alloc_req1,
        output alloc_ready, alloc_preg0, alloc_preg1,
        input  free_vld0, free_vld1, free_preg0, free_preg1,
        output free_ready,
        input  redirect, walk_vld0, walk_vld1, walk_preg0, walk_preg1, walk_done
    );
endinterface

// File: rtl/freelist_ctrl.sv
// Purpose : sequencer for the 2-read/2-write physical-register freelist.
//           Tracks the free count, packs sparse allocation requests and
//           frees onto freelist port 0 first, grants 2-wide allocations
//           all-or-nothing and runs the redirect walk that returns
//           speculatively allocated pregs.
// Ports   : clock, reset_n           - clock, synchronous active-low reset
//           bus (slave)              - alloc / free / walk handshakes
//           fl_rd_en0/1, fl_rd_data0/1  - freelist read ports
//           fl_wr_en0/1, fl_wr_data0/1  - freelist write ports
//           free_cnt                 - current number of free entries
//           err_ovf                  - sticky free-count overflow flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | normal operation: allocations and commit frees
// S_WALK   | redirect walk owns the write ports; alloc and commit stall
// S_RESUME | one-cycle bubble after the walk; frees accepted, no allocs
module freelist_ctrl #(
    parameter  int DATA_WIDTH = 6,
    parameter  int DEPTH      = 32,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    freelist_ctrl_if.slave        bus,
    output logic                  fl_rd_en0,
    output logic                  fl_rd_en1,
    input  logic [DATA_WIDTH-1:0] fl_rd_data0,
    input  logic [DATA_WIDTH-1:0] fl_rd_data1,
    output logic                  fl_wr_en0,
    output logic                  fl_wr_en1,
    output logic [DATA_WIDTH-1:0] fl_wr_data0,
    output logic [DATA_WIDTH-1:0] fl_wr_data1,
    output logic [CW-1:0]         free_cnt,
    output logic                  err_ovf
);
    typedef enum logic [1:0] {S_RUN, S_WALK, S_RESUME} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_free_cnt;
    logic            r_err_ovf;

    logic [1:0]      w_nreq;
    logic [1:0]      w_nrd;
    logic [1:0]      w_nwr;
    logic            w_grant;
    logic            w_in_walk;
    logic            w_wv0;
    logic            w_wv1;
    logic [DATA_WIDTH-1:0] w_wd0;
    logic [DATA_WIDTH-1:0] w_wd1;
    logic [CW:0]     w_sum;
    logic            w_ovf;

    always_comb begin
        w_nreq    = {1'b0, bus.alloc_req0} + {1'b0, bus.alloc_req1};
        // count check uses only the registered count: no same-cycle free bypass
        w_grant   = reset_n && (r_state == S_RUN) && !bus.redirect &&
                    (r_free_cnt >= CW'(w_nreq));
        w_nrd     = w_grant ? w_nreq : 2'd0;

        fl_rd_en0       = w_grant && (bus.alloc_req0 || bus.alloc_req1);
        fl_rd_en1       = w_grant && bus.alloc_req0 && bus.alloc_req1;
        bus.alloc_ready = w_grant;
        bus.alloc_preg0 = (w_grant && bus.alloc_req0) ? fl_rd_data0 : '0;
        bus.alloc_preg1 = '0;
        if (w_grant && bus.alloc_req1)
            bus.alloc_preg1 = bus.alloc_req0 ? fl_rd_data1 : fl_rd_data0;

        w_in_walk      = reset_n && (r_state == S_WALK);
        bus.free_ready = reset_n && (r_state != S_WALK);

        // walk owns the write ports in WALK; otherwise commit frees use them
        if (w_in_walk) begin
            w_wv0 = bus.walk_vld0;
            w_wv1 = bus.walk_vld1;
            w_wd0 = bus.walk_preg0;
            w_wd1 = bus.walk_preg1;
        end else begin
            w_wv0 = bus.free_ready && bus.free_vld0;
            w_wv1 = bus.free_ready && bus.free_vld1;
            w_wd0 = bus.free_preg0;
            w_wd1 = bus.free_preg1;
        end
        w_nwr = {1'b0, w_wv0} + {1'b0, w_wv1};

        // r_free_cnt >= w_nrd whenever a read is granted, so no underflow
        w_sum = {1'b0, r_free_cnt} - (CW + 1)'(w_nrd) + (CW + 1)'(w_nwr);
        w_ovf = (w_sum > (CW + 1)'(DEPTH));

        fl_wr_en0   = !w_ovf && (w_wv0 || w_wv1);
        fl_wr_en1   = !w_ovf && w_wv0 && w_wv1;
        fl_wr_data0 = w_wv0 ? w_wd0 : w_wd1;
        fl_wr_data1 = w_wd1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_RUN;
            r_free_cnt <= CW'(DEPTH);
            r_err_ovf  <= 1'b0;
        end else begin
            r_free_cnt <= w_ovf ? CW'(DEPTH) : w_sum[CW-1:0];
            if (w_ovf)
                r_err_ovf <= 1'b1;
            if (bus.redirect)
                r_state <= S_WALK;
            else begin
                case (r_state)
                    S_WALK:   if (bus.walk_done) r_state <= S_RESUME;
                    S_RESUME: r_state <= S_RUN;
                    default:  r_state <= S_RUN;
                endcase
            end
        end
    end

    assign free_cnt = r_free_cnt;
    assign err_ovf  = r_err_ovf;
endmodule
